// File: rtl/tc_pl_chips_stsmon.sv
// Status monitor and control register for on-board chip status lines.
// Each channel has a 2-flop synchroniser, a debouncer, edge-event detection,
// a sticky flag and a saturating event counter. The block also provides a
// masked interrupt, a registered readback port and a strobed control register.
module tc_pl_chips_stsmon #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned DB_W   = 8,
  parameter int unsigned DB_CNT = 125,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned EDGE   = 0,
  parameter int unsigned CTRL_W = 8,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0,
  localparam int unsigned SEL_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk125,
  input  logic              rst,
  input  logic [NCH-1:0]    sts_in,
  output logic [NCH-1:0]    sts_lvl,
  input  logic [NCH-1:0]    irq_mask,
  output logic              irq,
  input  logic              clr_w,
  input  logic [NCH-1:0]    clr_mask,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [CNT_W+1:0]  rd_data,
  input  logic [CTRL_W-1:0] ctrl_wdata,
  input  logic              ctrl_w,
  output logic [CTRL_W-1:0] ctrl_out
);

  logic [NCH-1:0]   s1;
  logic [NCH-1:0]   s2;
  logic [DB_W-1:0]  db_cnt [NCH];
  logic [NCH-1:0]   lvl_d;
  logic [NCH-1:0]   ev;
  logic [NCH-1:0]   clr_hit;
  logic [NCH-1:0]   sticky;
  logic [CNT_W-1:0] cnt [NCH];

  // Two-flop synchroniser for the asynchronous status pins
  always_ff @(posedge clk125 or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sts_in;
      s2 <= s1;
    end
  end

  // Debounce: accept a new level only after it persists for DB_CNT cycles
  always_ff @(posedge clk125 or posedge rst) begin
    if (rst) begin
      sts_lvl <= '0;
      for (int unsigned i = 0; i < NCH; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (s2[i] == sts_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DB_CNT - 1)) begin
          sts_lvl[i] <= s2[i];
          db_cnt[i]  <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Previous debounced level, used for edge detection
  always_ff @(posedge clk125 or posedge rst) begin
    if (rst) lvl_d <= '0;
    else     lvl_d <= sts_lvl;
  end

  // Event pulse for the selected edge type, and per-channel clear hits
  always_comb begin
    ev = '0;
    if (EDGE == 0)      ev = ~sts_lvl & lvl_d;
    else if (EDGE == 1) ev = sts_lvl & ~lvl_d;
    else                ev = sts_lvl ^ lvl_d;
    clr_hit = {NCH{clr_w}} & clr_mask;
  end

  // Sticky flags: an event wins over a simultaneous clear
  always_ff @(posedge clk125 or posedge rst) begin
    if (rst) sticky <= '0;
    else     sticky <= ev | (sticky & ~clr_hit);
  end

  // Saturating event counters; clear with a concurrent event lands on 1
  always_ff @(posedge clk125 or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (clr_hit[i])
          cnt[i] <= ev[i] ? CNT_W'(1) : '0;
        else if (ev[i] && (cnt[i] != '1))
          cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  // Masked interrupt, registered
  always_ff @(posedge clk125 or posedge rst) begin
    if (rst) irq <= 1'b0;
    else     irq <= |(sticky & irq_mask);
  end

  // Registered readback of the selected channel; out-of-range index reads 0
  always_ff @(posedge clk125 or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (32'(rd_sel) < NCH) begin
      rd_data <= {sticky[rd_sel], sts_lvl[rd_sel], cnt[rd_sel]};
    end else begin
      rd_data <= '0;
    end
  end

  // Strobed control register
  always_ff @(posedge clk125 or posedge rst) begin
    if (rst)         ctrl_out <= CTRL_RST;
    else if (ctrl_w) ctrl_out <= ctrl_wdata;
  end

endmodule

// File: tb/tb_tc_pl_chips_stsmon.sv
// Self-checking bench for tc_pl_chips_stsmon: directed scenarios followed by
// randomized traffic, all checked against a behavioural model.
module tb_tc_pl_chips_stsmon;

  localparam int NCH    = 5;
  localparam int DB_W   = 8;
  localparam int DB_CNT = 4;
  localparam int CNT_W  = 2;
  localparam int EDGE   = 0;
  localparam int CTRL_W = 8;
  localparam logic [7:0] CTRL_RST = 8'h3C;
  localparam int SEL_W  = 3;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk125 = 1'b0;
  logic              rst;
  logic [NCH-1:0]    sts_in;
  logic [NCH-1:0]    sts_lvl;
  logic [NCH-1:0]    irq_mask;
  logic              irq;
  logic              clr_w;
  logic [NCH-1:0]    clr_mask;
  logic [SEL_W-1:0]  rd_sel;
  logic [CNT_W+1:0]  rd_data;
  logic [7:0]        ctrl_wdata;
  logic              ctrl_w;
  logic [7:0]        ctrl_out;

  tc_pl_chips_stsmon #(
    .NCH(NCH), .DB_W(DB_W), .DB_CNT(DB_CNT), .CNT_W(CNT_W),
    .EDGE(EDGE), .CTRL_W(CTRL_W), .CTRL_RST(CTRL_RST)
  ) dut (
    .clk125(clk125), .rst(rst), .sts_in(sts_in), .sts_lvl(sts_lvl),
    .irq_mask(irq_mask), .irq(irq), .clr_w(clr_w), .clr_mask(clr_mask),
    .rd_sel(rd_sel), .rd_data(rd_data), .ctrl_wdata(ctrl_wdata),
    .ctrl_w(ctrl_w), .ctrl_out(ctrl_out)
  );

  always #4 clk125 = ~clk125;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model state
  logic [NCH-1:0] m_pipe [$];    // pin samples in flight: [0] oldest (synchronised)
  int             m_run [NCH];   // consecutive cycles the synced pin disagrees with level
  bit [NCH-1:0]   m_lvl, m_prev, m_sticky;
  int             m_cnt [NCH];
  bit             m_irq;
  int             m_rd;
  logic [7:0]     m_ctrl;

  task automatic model_reset();
    m_pipe = '{'0, '0};
    m_lvl = '0; m_prev = '0; m_sticky = '0;
    m_irq = 1'b0; m_rd = 0; m_ctrl = CTRL_RST;
    for (int i = 0; i < NCH; i++) begin m_run[i] = 0; m_cnt[i] = 0; end
  endtask

  function automatic bit is_event(input int i);
    bit rise = m_lvl[i] && !m_prev[i];
    bit fall = !m_lvl[i] && m_prev[i];
    return (EDGE == 0) ? fall : (EDGE == 1) ? rise : (rise || fall);
  endfunction

  // Advance the model by one clock using the currently driven inputs
  task automatic model_step();
    bit [NCH-1:0] ev;
    logic [NCH-1:0] synced;
    int sel;
    for (int i = 0; i < NCH; i++) ev[i] = is_event(i);
    sel = int'(rd_sel);
    m_rd = (sel < NCH) ? (int'(m_sticky[sel]) * (1 << (CNT_W + 1))
                          + int'(m_lvl[sel]) * (1 << CNT_W) + m_cnt[sel]) : 0;
    m_irq = (m_sticky & irq_mask) != '0;
    for (int i = 0; i < NCH; i++) begin
      bit clr = clr_w && clr_mask[i];
      if (clr)        m_cnt[i] = ev[i] ? 1 : 0;
      else if (ev[i]) m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
      m_sticky[i] = ev[i] || (m_sticky[i] && !clr);
    end
    m_prev = m_lvl;
    synced = m_pipe[0];
    for (int i = 0; i < NCH; i++) begin
      if (synced[i] == m_lvl[i]) m_run[i] = 0;
      else if (m_run[i] + 1 == DB_CNT) begin m_lvl[i] = synced[i]; m_run[i] = 0; end
      else m_run[i]++;
    end
    void'(m_pipe.pop_front());
    m_pipe.push_back(sts_in);
    if (ctrl_w) m_ctrl = ctrl_wdata;
  endtask

  task automatic compare_all();
    check("sts_lvl", 32'(sts_lvl), 32'(m_lvl));
    check("irq", 32'(irq), 32'(m_irq));
    check("rd_data", 32'(rd_data), 32'(m_rd));
    check("ctrl_out", 32'(ctrl_out), 32'(m_ctrl));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk125);
    #1;
    compare_all();
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // Asynchronous reset pulse in the middle of a cycle
  task automatic reset_pulse();
    #1 rst = 1'b1;
    #1;
    model_reset();
    check("rst_sts_lvl", 32'(sts_lvl), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_ctrl_out", 32'(ctrl_out), 32'(CTRL_RST));
    @(posedge clk125);
    #1 rst = 1'b0;
  endtask

  initial begin
    bit found;
    rst = 1'b1; sts_in = '0; irq_mask = '0; clr_w = 1'b0; clr_mask = '0;
    rd_sel = '0; ctrl_wdata = '0; ctrl_w = 1'b0;
    model_reset();
    #3;
    check("reset_sts_lvl", 32'(sts_lvl), 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'd0);
    check("reset_ctrl_out", 32'(ctrl_out), 32'(CTRL_RST));
    @(posedge clk125);
    #1 rst = 1'b0;

    // Rising lines qualify after DB_CNT+2 clocks; falling-edge mode: no event
    sts_in = '1;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      if (k == 5) check("t1_lvl_early", 32'(sts_lvl[0]), 32'd0);
      if (k == 6) check("t1_lvl_qualified", 32'(sts_lvl[0]), 32'd1);
    end
    rd_sel = 3'd0;
    cycle();
    check("t1_rd_no_event", 32'(rd_data), 32'b0100);

    // Short low glitch is filtered; a long low is an event with irq
    irq_mask = '1;
    rd_sel = 3'd1;
    sts_in[1] = 1'b0;
    cycles(3);
    sts_in[1] = 1'b1;
    cycles(10);
    check("t2_glitch_lvl", 32'(sts_lvl[1]), 32'd1);
    check("t2_glitch_rd", 32'(rd_data), 32'b0100);
    check("t2_glitch_irq", 32'(irq), 32'd0);
    sts_in[1] = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      cycle();
      found = irq;
    end
    check("t2_irq_seen", 32'(found), 32'd1);
    cycles(2);
    check("t2_rd_after_fall", 32'(rd_data), 32'b1001);

    // Counter saturation then selective clear
    rd_sel = 3'd2;
    for (int e = 0; e < 5; e++) begin
      sts_in[2] = 1'b0; cycles(8);
      sts_in[2] = 1'b1; cycles(8);
    end
    cycles(2);
    check("t3_saturated", 32'(rd_data), 32'b1111);
    clr_w = 1'b1; clr_mask = 5'b00100;
    cycle();
    clr_w = 1'b0; clr_mask = '0;
    cycles(2);
    check("t3_cleared", 32'(rd_data), 32'b0100);
    rd_sel = 3'd1;
    cycles(2);
    check("t3_other_untouched", 32'(rd_data), 32'b1001);

    // Clear coinciding with an event: sticky stays set and count lands on 1
    rd_sel = 3'd0;
    sts_in[0] = 1'b0; cycles(10);
    sts_in[0] = 1'b1; cycles(10);
    check("t4_pre_count", 32'(rd_data), 32'b1101);
    sts_in[0] = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle();
      found = !sts_lvl[0];
    end
    check("t4_fall_seen", 32'(found), 32'd1);
    clr_w = 1'b1; clr_mask = 5'b00001;
    cycle();
    clr_w = 1'b0; clr_mask = '0;
    cycles(2);
    check("t4_clear_vs_event", 32'(rd_data), 32'b1001);

    // Control register write, then asynchronous reset
    ctrl_wdata = 8'hA5; ctrl_w = 1'b1;
    cycle();
    ctrl_w = 1'b0; ctrl_wdata = 8'h00;
    check("t5_ctrl_write", 32'(ctrl_out), 32'hA5);
    clr_w = 1'b1; clr_mask = '1;
    cycle();
    clr_w = 1'b0; clr_mask = '0;
    check("t5_ctrl_vs_clr", 32'(ctrl_out), 32'hA5);
    reset_pulse();

    // Readback selection and out-of-range index
    cycles(8);
    rd_sel = 3'd3;
    cycle();
    check("t6_rd_ch3", 32'(rd_data), 32'b0100);
    rd_sel = 3'd5;
    cycle();
    check("t6_rd_oob5", 32'(rd_data), 32'd0);
    rd_sel = 3'd7;
    cycle();
    check("t6_rd_oob7", 32'(rd_data), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) sts_in[$urandom_range(0, NCH - 1)] ^= 1'b1;
      clr_w = ($urandom_range(0, 9) == 0);
      clr_mask = NCH'($urandom);
      if ($urandom_range(0, 19) == 0) irq_mask = NCH'($urandom);
      rd_sel = SEL_W'($urandom);
      ctrl_w = ($urandom_range(0, 7) == 0);
      ctrl_wdata = 8'($urandom);
      if ($urandom_range(0, 499) == 0) reset_pulse();
      else cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
